// File: rtl/rt_mem_pkg.sv
// Shared RT-domain memory definitions: ROM arbiter state encoding and the
// ROM burst/timeout constants also used by the I-cache line-fill engine.
package rt_mem_pkg;

    localparam int unsigned RT_ROM_BURST_LEN = 8;
    localparam int unsigned RT_ROM_TIMEOUT   = 100;

    typedef enum logic [1:0] {
        StIdle,
        StGrantM0,
        StGrantM1,
        StAbort
    } rom_arb_state_t;

endpackage

// File: rtl/rt_rom_arb_timeout.sv
// Stall watchdog for the ROM arbiter: counts granted cycles without rom_ready,
// flags expiry, and keeps the saturating count of aborted grants.
module rt_rom_arb_timeout
    import rt_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = RT_ROM_TIMEOUT
) (
    input  logic        clk_rt_50mhz,
    input  logic        rst_n,
    input  logic        granted_i,
    input  logic        rom_ready_i,
    input  logic        abort_i,
    output logic        expired_o,
    output logic [15:0] timeout_count_o
);

    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [15:0]      tcount_q, tcount_d;

    always_comb begin
        wait_cnt_d = '0;
        if (granted_i && !rom_ready_i) begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
        tcount_d = tcount_q;
        if (abort_i && (tcount_q != 16'hFFFF)) begin
            tcount_d = tcount_q + 16'd1;
        end
    end

    // Expiry fires in the cycle that would make wait_cnt reach TIMEOUT, so the
    // abort cycle itself is the TIMEOUT-th cycle after the last progress.
    assign expired_o       = granted_i && !rom_ready_i && (wait_cnt_q == WaitW'(TIMEOUT - 1));
    assign timeout_count_o = tcount_q;

    always_ff @(posedge clk_rt_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            tcount_q   <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            tcount_q   <= tcount_d;
        end
    end

endmodule

// File: rtl/rt_rom_arbiter.sv
// Two-master ROM port arbiter: m0 (I-cache fill) has priority, m1 (boot/debug)
// is guaranteed a burst after MAX_M0_BURSTS contested m0 bursts.
module rt_rom_arbiter
    import rt_mem_pkg::*;
#(
    parameter int unsigned BURST_LEN     = RT_ROM_BURST_LEN,
    parameter int unsigned MAX_M0_BURSTS = 4,
    parameter int unsigned TIMEOUT       = RT_ROM_TIMEOUT
) (
    input  logic        clk_rt_50mhz,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m1_addr,
    output logic [15:0] m0_data,
    output logic [15:0] m1_data,
    output logic        m0_ready,
    output logic        m1_ready,
    output logic        m0_err,
    output logic        m1_err,
    output logic        rom_req,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_data,
    input  logic        rom_ready,
    output logic [1:0]  grant,
    output logic [15:0] timeout_count
);

    localparam int unsigned WordW   = $clog2(BURST_LEN + 1);
    localparam int unsigned StarveW = $clog2(MAX_M0_BURSTS + 1);

    rom_arb_state_t     state_q, state_d;
    logic               owner_q, owner_d;  // 1: last grant was m1
    logic [WordW-1:0]   word_cnt_q, word_cnt_d;
    logic               low_q, low_d;
    logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;

    logic        granted, expired, cur_req, word_done, req_gone, leave, starved;
    logic [15:0] cur_addr;

    assign granted   = (state_q == StGrantM0) || (state_q == StGrantM1);
    assign cur_req   = (state_q == StGrantM1) ? m1_req  : m0_req;
    assign cur_addr  = (state_q == StGrantM1) ? m1_addr : m0_addr;
    assign word_done = granted && rom_ready && (word_cnt_q == WordW'(BURST_LEN - 1));
    assign req_gone  = granted && !cur_req && low_q;
    assign leave     = word_done || req_gone || expired;
    assign starved   = (starve_cnt_q == StarveW'(MAX_M0_BURSTS));

    assign m0_data = rom_data;
    assign m1_data = rom_data;

    rt_rom_arb_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk_rt_50mhz   (clk_rt_50mhz),
        .rst_n          (rst_n),
        .granted_i      (granted),
        .rom_ready_i    (rom_ready),
        .abort_i        (state_q == StAbort),
        .expired_o      (expired),
        .timeout_count_o(timeout_count)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        word_cnt_d   = word_cnt_q;
        low_d        = low_q;
        starve_cnt_d = starve_cnt_q;
        rom_req      = 1'b0;
        rom_addr     = '0;
        m0_ready     = 1'b0;
        m1_ready     = 1'b0;
        m0_err       = 1'b0;
        m1_err       = 1'b0;
        grant        = 2'b00;
        unique case (state_q)
            StIdle: begin
                word_cnt_d = '0;
                low_d      = 1'b0;
                if (!m1_req) begin
                    starve_cnt_d = '0;
                end
                if (m1_req && (!m0_req || starved)) begin
                    state_d      = StGrantM1;
                    owner_d      = 1'b1;
                    starve_cnt_d = '0;
                end else if (m0_req) begin
                    state_d = StGrantM0;
                    owner_d = 1'b0;
                end
            end
            StGrantM0, StGrantM1: begin
                grant    = (state_q == StGrantM1) ? 2'b10 : 2'b01;
                rom_req  = cur_req;
                rom_addr = cur_addr;
                if (state_q == StGrantM1) begin
                    m1_ready = rom_ready;
                end else begin
                    m0_ready = rom_ready;
                end
                if (rom_ready) begin
                    word_cnt_d = word_cnt_q + WordW'(1);
                end
                low_d = !cur_req;
                // A completed word outranks a simultaneous timeout.
                if (word_done || req_gone) begin
                    state_d = StIdle;
                end else if (expired) begin
                    state_d = StAbort;
                end
                if (leave && (state_q == StGrantM0) && m1_req && !starved) begin
                    starve_cnt_d = starve_cnt_q + StarveW'(1);
                end
            end
            StAbort: begin
                m0_err  = !owner_q;
                m1_err  = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_rt_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            word_cnt_q   <= '0;
            low_q        <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            word_cnt_q   <= word_cnt_d;
            low_q        <= low_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_rt_rom_arbiter.sv
// Directed self-checking bench for rt_rom_arbiter; inputs change 2 time units
// after each rising edge and outputs are sampled 1 unit later.
module tb_rt_rom_arbiter;

    logic        clk_rt_50mhz;
    logic        rst_n;
    logic        m0_req, m1_req;
    logic [15:0] m0_addr, m1_addr;
    logic [15:0] m0_data, m1_data;
    logic        m0_ready, m1_ready, m0_err, m1_err;
    logic        rom_req;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic        rom_ready;
    logic [1:0]  grant;
    logic [15:0] timeout_count;

    int n_chk;
    int n_pass;

    rt_rom_arbiter dut (
        .clk_rt_50mhz (clk_rt_50mhz),
        .rst_n        (rst_n),
        .m0_req       (m0_req),
        .m1_req       (m1_req),
        .m0_addr      (m0_addr),
        .m1_addr      (m1_addr),
        .m0_data      (m0_data),
        .m1_data      (m1_data),
        .m0_ready     (m0_ready),
        .m1_ready     (m1_ready),
        .m0_err       (m0_err),
        .m1_err       (m1_err),
        .rom_req      (rom_req),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .rom_ready    (rom_ready),
        .grant        (grant),
        .timeout_count(timeout_count)
    );

    initial begin
        clk_rt_50mhz = 1'b0;
        forever #10 clk_rt_50mhz = ~clk_rt_50mhz;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk_rt_50mhz);
        #2;
    endtask

    // Leaves the bench 2 units after an edge, DUT in IDLE, all inputs quiet.
    task automatic do_reset();
        rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m0_addr = '0; m1_addr = '0;
        rom_data = '0; rom_ready = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0; m0_req = 1'b1; m1_req = 1'b1; rom_ready = 1'b1;
        #1;
        n_chk++; if (grant !== 2'b00) $display("FAIL rst_grant: got %b want 00", grant); else n_pass++;
        n_chk++; if (rom_req !== 1'b0) $display("FAIL rst_rom_req: got %b want 0", rom_req); else n_pass++;
        n_chk++; if (rom_addr !== 16'h0) $display("FAIL rst_rom_addr: got %h want 0000", rom_addr); else n_pass++;
        n_chk++; if ({m0_ready, m1_ready, m0_err, m1_err} !== 4'b0)
            $display("FAIL rst_strobes: got %b want 0000", {m0_ready, m1_ready, m0_err, m1_err});
        else n_pass++;
        n_chk++; if (timeout_count !== 16'h0) $display("FAIL rst_tcount: got %h want 0000", timeout_count); else n_pass++;
    endtask

    task automatic test_m0_burst();
        int nrdy = 0;
        do_reset();
        m0_req = 1'b1; m0_addr = 16'h0040;
        #1;
        n_chk++; if (grant !== 2'b00) $display("FAIL m0_pre_grant: got %b want 00", grant); else n_pass++;
        for (int w = 0; w < 8; w++) begin
            for (int d = 1; d <= 3; d++) begin
                next_cycle();
                if (d == 1 && w > 0) m0_addr = 16'h0040 + 16'(w);
                rom_ready = (d == 3);
                rom_data  = 16'hC000 + 16'(w);
                #1;
                if (m0_ready) nrdy++;
                if (w == 0 && d == 1) begin
                    n_chk++; if (grant !== 2'b01) $display("FAIL m0_first_grant: got %b want 01", grant); else n_pass++;
                    n_chk++; if (rom_req !== 1'b1) $display("FAIL m0_first_req: got %b want 1", rom_req); else n_pass++;
                end
                if (d == 3) begin
                    n_chk++; if (m0_ready !== 1'b1) $display("FAIL m0_ready_w%0d: got %b want 1", w, m0_ready); else n_pass++;
                    n_chk++; if (rom_addr !== 16'h0040 + 16'(w))
                        $display("FAIL m0_addr_w%0d: got %h want %h", w, rom_addr, 16'h0040 + 16'(w));
                    else n_pass++;
                    n_chk++; if (m0_data !== 16'hC000 + 16'(w))
                        $display("FAIL m0_data_w%0d: got %h want %h", w, m0_data, 16'hC000 + 16'(w));
                    else n_pass++;
                    n_chk++; if (m1_ready !== 1'b0) $display("FAIL m0_m1_ready_w%0d: got %b want 0", w, m1_ready); else n_pass++;
                end
            end
        end
        next_cycle();
        m0_req = 1'b0; rom_ready = 1'b0;
        #1;
        n_chk++; if (grant !== 2'b00) $display("FAIL m0_end_idle: got %b want 00", grant); else n_pass++;
        n_chk++; if (rom_req !== 1'b0) $display("FAIL m0_end_req: got %b want 0", rom_req); else n_pass++;
        n_chk++; if (nrdy !== 8) $display("FAIL m0_ready_count: got %0d want 8", nrdy); else n_pass++;
    endtask

    // Both masters request continuously with a zero-latency ROM: bursts are 8
    // cycles plus one IDLE bubble, and the fifth burst goes to m1.
    task automatic test_starvation();
        logic [1:0] exp_g;
        do_reset();
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 16'h1000; m1_addr = 16'h2000;
        rom_ready = 1'b1; rom_data = 16'h5A5A;
        #1;
        for (int c = 1; c <= 46; c++) begin
            next_cycle();
            #1;
            if ((c - 1) % 9 == 8) exp_g = 2'b00;
            else if ((c - 1) / 9 == 4) exp_g = 2'b10;
            else exp_g = 2'b01;
            n_chk++; if (grant !== exp_g) $display("FAIL starve_grant_c%0d: got %b want %b", c, grant, exp_g); else n_pass++;
            if (c == 36) begin
                n_chk++; if (dut.starve_cnt_q !== 3'd4)
                    $display("FAIL starve_cnt_full: got %0d want 4", dut.starve_cnt_q);
                else n_pass++;
            end
            if (c == 37) begin
                n_chk++; if (dut.starve_cnt_q !== 3'd0)
                    $display("FAIL starve_cnt_clear: got %0d want 0", dut.starve_cnt_q);
                else n_pass++;
                n_chk++; if (rom_addr !== 16'h2000) $display("FAIL starve_m1_addr: got %h want 2000", rom_addr); else n_pass++;
                n_chk++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0)
                    $display("FAIL starve_m1_ready: got m1=%b m0=%b want m1=1 m0=0", m1_ready, m0_ready);
                else n_pass++;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0; rom_ready = 1'b0;
    endtask

    task automatic test_gap();
        do_reset();
        m0_req = 1'b1; m0_addr = 16'h0100; m1_req = 1'b1; m1_addr = 16'h0200;
        #1;
        next_cycle(); rom_ready = 1'b1; #1;
        n_chk++; if (grant !== 2'b01) $display("FAIL gap_grant0: got %b want 01", grant); else n_pass++;
        next_cycle(); m0_req = 1'b0; rom_ready = 1'b0; #1;
        n_chk++; if (rom_req !== 1'b0) $display("FAIL gap_req_low: got %b want 0", rom_req); else n_pass++;
        next_cycle(); m0_req = 1'b1; m0_addr = 16'h0101; rom_ready = 1'b1; #1;
        n_chk++; if (grant !== 2'b01) $display("FAIL gap_one_low_kept: got %b want 01", grant); else n_pass++;
        n_chk++; if (m0_ready !== 1'b1 || m1_ready !== 1'b0)
            $display("FAIL gap_ready: got m0=%b m1=%b want m0=1 m1=0", m0_ready, m1_ready);
        else n_pass++;
        next_cycle(); m0_req = 1'b0; rom_ready = 1'b0; #1;
        next_cycle(); #1;
        n_chk++; if (grant !== 2'b01) $display("FAIL gap_second_low: got %b want 01", grant); else n_pass++;
        next_cycle(); #1;
        n_chk++; if (grant !== 2'b00) $display("FAIL gap_released: got %b want 00", grant); else n_pass++;
        next_cycle(); #1;
        n_chk++; if (grant !== 2'b10) $display("FAIL gap_m1_granted: got %b want 10", grant); else n_pass++;
        n_chk++; if (rom_req !== 1'b1 || rom_addr !== 16'h0200)
            $display("FAIL gap_m1_rom: got req=%b addr=%h want req=1 addr=0200", rom_req, rom_addr);
        else n_pass++;
        m1_req = 1'b0;
    endtask

    task automatic test_timeout();
        int errs = 0;
        int gbad = 0;
        do_reset();
        m1_req = 1'b1; m1_addr = 16'h0300;
        #1;
        for (int k = 0; k < 100; k++) begin
            next_cycle(); #1;
            if (m0_err || m1_err) errs++;
            if (grant !== 2'b10) gbad++;
        end
        n_chk++; if (errs !== 0) $display("FAIL to_early_err: got %0d pulses want 0", errs); else n_pass++;
        n_chk++; if (gbad !== 0) $display("FAIL to_grant_held: got %0d bad cycles want 0", gbad); else n_pass++;
        next_cycle(); #1;
        n_chk++; if (m1_err !== 1'b1 || m0_err !== 1'b0)
            $display("FAIL to_err_pulse: got m1=%b m0=%b want m1=1 m0=0", m1_err, m0_err);
        else n_pass++;
        n_chk++; if (rom_req !== 1'b0) $display("FAIL to_abort_req: got %b want 0", rom_req); else n_pass++;
        next_cycle(); #1;
        n_chk++; if (grant !== 2'b00) $display("FAIL to_idle: got %b want 00", grant); else n_pass++;
        n_chk++; if (m1_err !== 1'b0) $display("FAIL to_err_one_cycle: got %b want 0", m1_err); else n_pass++;
        n_chk++; if (timeout_count !== 16'd1) $display("FAIL to_count: got %0d want 1", timeout_count); else n_pass++;
        m1_req = 1'b0;
    endtask

    // Ready on the last word lands exactly in the cycle that would otherwise expire.
    task automatic test_ready_wins();
        int errs = 0;
        int nrdy = 0;
        do_reset();
        m0_req = 1'b1; m0_addr = 16'h0500;
        #1;
        for (int k = 0; k <= 106; k++) begin
            next_cycle();
            m0_addr   = 16'h0500 + 16'(nrdy);
            rom_ready = (k < 7) || (k == 106);
            rom_data  = 16'hB000 + 16'(k);
            #1;
            if (m0_err || m1_err) errs++;
            if (m0_ready) nrdy++;
            if (k == 105) begin
                n_chk++; if (grant !== 2'b01) $display("FAIL rw_grant_held: got %b want 01", grant); else n_pass++;
            end
            if (k == 106) begin
                n_chk++; if (m0_ready !== 1'b1) $display("FAIL rw_last_ready: got %b want 1", m0_ready); else n_pass++;
            end
        end
        next_cycle(); m0_req = 1'b0; rom_ready = 1'b0; #1;
        if (m0_err || m1_err) errs++;
        n_chk++; if (grant !== 2'b00) $display("FAIL rw_idle: got %b want 00", grant); else n_pass++;
        next_cycle(); #1;
        if (m0_err || m1_err) errs++;
        n_chk++; if (errs !== 0) $display("FAIL rw_no_err: got %0d pulses want 0", errs); else n_pass++;
        n_chk++; if (timeout_count !== 16'd0) $display("FAIL rw_count: got %0d want 0", timeout_count); else n_pass++;
        n_chk++; if (nrdy !== 8) $display("FAIL rw_ready_count: got %0d want 8", nrdy); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        m0_req = 1'b1; m0_addr = 16'h0040;
        #1;
        for (int k = 0; k < 3; k++) begin
            next_cycle(); m0_addr = 16'h0040 + 16'(k); rom_ready = 1'b1; #1;
        end
        next_cycle(); m0_addr = 16'h0043; rom_ready = 1'b1; #1;
        n_chk++; if (grant !== 2'b01) $display("FAIL rmb_pre_grant: got %b want 01", grant); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++; if (grant !== 2'b00) $display("FAIL rmb_grant: got %b want 00", grant); else n_pass++;
        n_chk++; if (rom_req !== 1'b0) $display("FAIL rmb_rom_req: got %b want 0", rom_req); else n_pass++;
        n_chk++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0)
            $display("FAIL rmb_ready: got m0=%b m1=%b want 0 0", m0_ready, m1_ready);
        else n_pass++;
        next_cycle();
        rst_n = 1'b1; m0_addr = 16'h0060; rom_ready = 1'b0;
        #1;
        for (int k = 0; k <= 8; k++) begin
            next_cycle(); rom_ready = (k < 8); m0_addr = 16'h0060 + 16'(k); #1;
            if (k == 7) begin
                n_chk++; if (grant !== 2'b01) $display("FAIL rmb_full_burst: got %b want 01", grant); else n_pass++;
            end
        end
        n_chk++; if (grant !== 2'b00) $display("FAIL rmb_restart_idle: got %b want 00", grant); else n_pass++;
        m0_req = 1'b0; rom_ready = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        test_reset();
        test_m0_burst();
        test_starvation();
        test_gap();
        test_timeout();
        test_ready_wins();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
